guess_judge: RTL and testbench
==============================

Name: guess_judge

Overview:
- Downstream consumer of the 7-bit LFSR value and the 1 s slow clock on the DE10-Lite board.
- Runs a number-guessing round:
  - latches a random target;
  - accepts player guesses from SW on a KEY press;
  - drives higher/lower hints, a try counter and a round timeout to the LEDs.
- Sits between the LFSR/clock-divider pair and the LEDR/HEX display logic in top.

Parameters:
- WIDTH, 7, width of target and guess (matches LFSR #(7)).
- MAX_TRIES, 7, guesses allowed per round (1..15).
- TIMEOUT_TICKS, 30, slow-clock ticks per round before forced loss (1..255).

Ports:
- clk  input  1  system clock, 10 MHz ADC_CLK_10.
- rst  input  1  synchronous, active-high reset.
- slow_clk  input  1  clock-divider output, sampled as data, rising edges counted as ticks.
- rand_num  input  WIDTH  free-running LFSR value.
- guess  input  WIDTH  player guess from SW.
- submit  input  1  guess-submit level, active-high, from the debounced KEY.
- start  input  1  new-round request level, active-high.
- hint_hi  output  1  last guess was above the target.
- hint_lo  output  1  last guess was below the target.
- win  output  1  round won.
- lose  output  1  round lost.
- tries  output  4  guesses used this round.
- time_left  output  8  ticks remaining.
- playing  output  1  FSM is in PLAY.

Behaviour:
- All inputs are synchronous to clk; synchronisers and debounce are upstream. All outputs are registered.
- Edge detect on slow_clk, submit and start:
  - Each has a prev register.
  - An event is cur & ~prev.
  - Prev registers reset to 1, so a level held high across reset produces no event.
- Reset (any cycle, including mid-round):
  - state = IDLE, target = 0, tries = 0, time_left = 0;
  - hint_hi = hint_lo = win = lose = playing = 0.
- States: IDLE, PLAY, WIN, LOSE. Every event's effect is visible on the outputs in the clk cycle after the event cycle.
- IDLE:
  - A start event moves the FSM to PLAY and loads:
    - target = rand_num as sampled in the event cycle;
    - tries = 0;
    - time_left = TIMEOUT_TICKS;
    - hints = 0; playing = 1.
  - submit and tick events are ignored.
- PLAY, on a submit event:
  - tries increments (saturates at 15).
  - guess == target (unsigned compare) → WIN; hints cleared; win = 1.
  - guess > target → hint_hi = 1, hint_lo = 0.
  - guess < target → hint_lo = 1, hint_hi = 0.
  - A wrong guess that makes tries == MAX_TRIES → LOSE; hints keep their last value.
- PLAY, on a tick event:
  - time_left decrements.
  - A decrement from 1 to 0 → LOSE.
- Simultaneous submit and tick events in PLAY:
  - The submit is evaluated first; a correct guess wins, even if the same tick expires the timer.
  - Otherwise the tick is also applied, and either loss condition → LOSE.
- A start event in PLAY is ignored. No mid-round restart.
- WIN/LOSE:
  - Outputs hold; playing = 0; submit and tick are ignored.
  - A start event begins a new round exactly as from IDLE: new target, win and lose cleared.
- time_left never wraps below 0. tries never wraps.

Optional Feature:
- Macro GUESS_TIMEOUT_EN.
- Defined: tick counting and timeout loss as above.
- Undefined:
  - slow_clk is unused;
  - time_left is held at TIMEOUT_TICKS during PLAY and 0 otherwise;
  - LOSE is reached only via MAX_TRIES.

Test Plan:
- Reset then no stimulus → all outputs 0, state IDLE. Hold submit = 1 through reset release → tries stays 0.
- rand_num = 42, start pulse → one cycle later playing = 1, tries = 0, time_left = 30. Then guess = 50 submit → hint_hi = 1, tries = 1. Then guess = 10 submit → hint_lo = 1, tries = 2. Then guess = 42 submit → win = 1, playing = 0, tries = 3.
- Target 42, seven wrong guesses of 0 → lose = 1 after the 7th, tries = 7. An 8th submit changes nothing.
- Target 5, 30 slow_clk rising edges, no submit → time_left counts 30..0, lose = 1 on the edge to 0. Repeat with GUESS_TIMEOUT_EN undefined → no loss, time_left stays 30.
- time_left = 1: submit guess == target in the same cycle as a tick event → win = 1, lose = 0.
- Mid-round rst (tries = 3) → next cycle IDLE with all outputs 0. Then start with rand_num = 99 → new target 99: guess 99 wins on the first try.

Source files
------------

// File: rtl/guess_judge.sv
// Number-guessing round judge: latches an LFSR target, scores SW guesses on KEY
// presses, and drives hint/try/timeout status. Round timeout enabled by GUESS_TIMEOUT_EN.
module guess_judge #(
  parameter int unsigned WIDTH         = 7,
  parameter int unsigned MAX_TRIES     = 7,
  parameter int unsigned TIMEOUT_TICKS = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic [WIDTH-1:0] rand_num,
  input  logic [WIDTH-1:0] guess,
  input  logic             submit,
  input  logic             start,
  output logic             hint_hi,
  output logic             hint_lo,
  output logic             win,
  output logic             lose,
  output logic [3:0]       tries,
  output logic [7:0]       time_left,
  output logic             playing
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_WIN,
    S_LOSE
  } state_e;

  localparam logic [3:0] MaxTries     = 4'(MAX_TRIES);
  localparam logic [7:0] TimeoutTicks = 8'(TIMEOUT_TICKS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [3:0]       tries_q, tries_d;
  logic [7:0]       time_left_q, time_left_d;
  logic             hint_hi_q, hint_hi_d;
  logic             hint_lo_q, hint_lo_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;
  logic             playing_q, playing_d;

  logic             submit_prev_q, start_prev_q;
  logic             submit_ev, start_ev;
  logic             won, lost;
  logic [3:0]       tries_inc;

  assign submit_ev = submit & ~submit_prev_q;
  assign start_ev  = start & ~start_prev_q;
  assign tries_inc = (tries_q == 4'hF) ? tries_q : tries_q + 4'd1;

`ifdef GUESS_TIMEOUT_EN
  logic slow_prev_q;
  logic tick_ev;

  assign tick_ev = slow_clk & ~slow_prev_q;

  always_ff @(posedge clk) begin
    if (rst) slow_prev_q <= 1'b1;
    else     slow_prev_q <= slow_clk;
  end
`else
  logic unused_slow_clk;
  assign unused_slow_clk = slow_clk;
`endif

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    tries_d     = tries_q;
    time_left_d = time_left_q;
    hint_hi_d   = hint_hi_q;
    hint_lo_d   = hint_lo_q;
    win_d       = win_q;
    lose_d      = lose_q;
    playing_d   = playing_q;
    won         = 1'b0;
    lost        = 1'b0;

    case (state_q)
      S_PLAY: begin
        if (submit_ev) begin
          tries_d = tries_inc;
          if (guess == target_q) begin
            won = 1'b1;
          end else begin
            hint_hi_d = (guess > target_q);
            hint_lo_d = (guess < target_q);
            if (tries_inc == MaxTries) lost = 1'b1;
          end
        end
`ifdef GUESS_TIMEOUT_EN
        // A correct guess takes priority: the coincident tick is discarded.
        if (tick_ev && !won) begin
          if (time_left_q != 8'd0) time_left_d = time_left_q - 8'd1;
          if (time_left_q == 8'd1) lost = 1'b1;
        end
`endif
        if (won) begin
          state_d   = S_WIN;
          win_d     = 1'b1;
          hint_hi_d = 1'b0;
          hint_lo_d = 1'b0;
          playing_d = 1'b0;
        end else if (lost) begin
          state_d   = S_LOSE;
          lose_d    = 1'b1;
          playing_d = 1'b0;
        end
`ifndef GUESS_TIMEOUT_EN
        if (won || lost) time_left_d = '0;
`endif
      end
      default: begin
        if (start_ev) begin
          state_d     = S_PLAY;
          target_d    = rand_num;
          tries_d     = '0;
          time_left_d = TimeoutTicks;
          hint_hi_d   = 1'b0;
          hint_lo_d   = 1'b0;
          win_d       = 1'b0;
          lose_d      = 1'b0;
          playing_d   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      target_q      <= '0;
      tries_q       <= '0;
      time_left_q   <= '0;
      hint_hi_q     <= 1'b0;
      hint_lo_q     <= 1'b0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
      playing_q     <= 1'b0;
      submit_prev_q <= 1'b1;
      start_prev_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      tries_q       <= tries_d;
      time_left_q   <= time_left_d;
      hint_hi_q     <= hint_hi_d;
      hint_lo_q     <= hint_lo_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
      playing_q     <= playing_d;
      submit_prev_q <= submit;
      start_prev_q  <= start;
    end
  end

  assign hint_hi   = hint_hi_q;
  assign hint_lo   = hint_lo_q;
  assign win       = win_q;
  assign lose      = lose_q;
  assign tries     = tries_q;
  assign time_left = time_left_q;
  assign playing   = playing_q;

endmodule

// File: tb/tb_guess_judge.sv
// Bench for guess_judge: directed round scenarios plus randomized play, all
// scored against a round-level behavioural model.
module tb_guess_judge;

  localparam int WIDTH   = 7;
  localparam int MAXT    = 7;
  localparam int TICKS   = 30;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             slow_clk = 1'b0;
  logic [WIDTH-1:0] rand_num = '0;
  logic [WIDTH-1:0] guess = '0;
  logic             submit = 1'b0;
  logic             start = 1'b0;
  logic             hint_hi, hint_lo, win, lose, playing;
  logic [3:0]       tries;
  logic [7:0]       time_left;

  int n_checks = 0;
  int n_errors = 0;

  guess_judge #(.WIDTH(WIDTH), .MAX_TRIES(MAXT), .TIMEOUT_TICKS(TICKS)) dut (
    .clk(clk), .rst(rst), .slow_clk(slow_clk), .rand_num(rand_num),
    .guess(guess), .submit(submit), .start(start), .hint_hi(hint_hi),
    .hint_lo(hint_lo), .win(win), .lose(lose), .tries(tries),
    .time_left(time_left), .playing(playing)
  );

  always #50 clk = ~clk;

  // Round-level reference: a round is either running or finished (won/lost/never started).
  bit m_pslow = 1, m_psub = 1, m_pstart = 1;
  bit m_hi, m_lo, m_win, m_lose, m_play;
  int m_target, m_tries, m_time;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit sub_ev, tick_ev, start_ev, correct, out_of_tries, out_of_time;
    if (rst) begin
      {m_hi, m_lo, m_win, m_lose, m_play} = '0;
      m_target = 0; m_tries = 0; m_time = 0;
      m_pslow = 1; m_psub = 1; m_pstart = 1;
      return;
    end
    sub_ev = submit && !m_psub;
    tick_ev = slow_clk && !m_pslow;
    start_ev = start && !m_pstart;
    if (m_play) begin
      correct = sub_ev && (int'(guess) == m_target);
      out_of_tries = 0;
      out_of_time = 0;
      if (sub_ev) begin
        m_tries = (m_tries < 15) ? m_tries + 1 : 15;
        if (!correct) begin
          m_hi = int'(guess) > m_target;
          m_lo = int'(guess) < m_target;
          out_of_tries = (m_tries == MAXT);
        end
      end
`ifdef GUESS_TIMEOUT_EN
      if (tick_ev && !correct && m_time > 0) begin
        m_time--;
        out_of_time = (m_time == 0);
      end
`endif
      if (correct) begin
        m_win = 1; m_hi = 0; m_lo = 0; m_play = 0;
      end else if (out_of_tries || out_of_time) begin
        m_lose = 1; m_play = 0;
      end
`ifndef GUESS_TIMEOUT_EN
      if (!m_play) m_time = 0;
`endif
    end else if (start_ev) begin
      m_target = int'(rand_num);
      m_tries = 0; m_time = TICKS;
      m_hi = 0; m_lo = 0; m_win = 0; m_lose = 0; m_play = 1;
    end
    m_pslow = slow_clk; m_psub = submit; m_pstart = start;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_eq("m_hint_hi", 32'(hint_hi), 32'(m_hi));
    check_eq("m_hint_lo", 32'(hint_lo), 32'(m_lo));
    check_eq("m_win", 32'(win), 32'(m_win));
    check_eq("m_lose", 32'(lose), 32'(m_lose));
    check_eq("m_tries", 32'(tries), 32'(m_tries));
    check_eq("m_time_left", 32'(time_left), 32'(m_time));
    check_eq("m_playing", 32'(playing), 32'(m_play));
  endtask

  task automatic new_round(input int tgt);
    rand_num = WIDTH'(tgt);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic do_guess(input int g);
    guess = WIDTH'(g);
    submit = 1'b1;
    step();
    submit = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_outs"}, 32'({hint_hi, hint_lo, win, lose, playing}), 32'd0);
    check_eq({tag, "_tries"}, 32'(tries), 32'd0);
    check_eq({tag, "_time"}, 32'(time_left), 32'd0);
  endtask

  initial begin
    // Reset with submit held high across release: no phantom guess.
    rst = 1'b1; submit = 1'b1;
    repeat (2) step();
    check_idle("reset");
    rst = 1'b0;
    repeat (3) step();
    check_idle("submit_held");
    submit = 1'b0;
    step();

    // Basic round, target 42.
    rand_num = 7'd42; start = 1'b1;
    step();
    start = 1'b0;
    check_eq("start_playing", 32'(playing), 32'd1);
    check_eq("start_tries", 32'(tries), 32'd0);
    check_eq("start_time", 32'(time_left), 32'd30);
    step();
    do_guess(50);
    check_eq("g50_hi", 32'({hint_hi, hint_lo}), 32'b10);
    check_eq("g50_tries", 32'(tries), 32'd1);
    step();
    do_guess(10);
    check_eq("g10_lo", 32'({hint_hi, hint_lo}), 32'b01);
    check_eq("g10_tries", 32'(tries), 32'd2);
    step();
    do_guess(42);
    check_eq("g42_win", 32'({win, lose, playing}), 32'b100);
    check_eq("g42_tries", 32'(tries), 32'd3);
    step();

    // Seven wrong guesses exhaust the round; an eighth is ignored.
    new_round(42);
    for (int i = 1; i <= 7; i++) begin
      do_guess(0);
      check_eq("wrong_lose", 32'(lose), (i == 7) ? 32'd1 : 32'd0);
      step();
    end
    check_eq("maxtries_tries", 32'(tries), 32'd7);
    do_guess(0);
    check_eq("after_lose_tries", 32'(tries), 32'd7);
    check_eq("after_lose_lose", 32'(lose), 32'd1);
    step();

    // Thirty slow ticks without guessing.
    new_round(5);
    for (int i = 1; i <= TICKS; i++) begin
      slow_clk = 1'b1;
      step();
      slow_clk = 1'b0;
`ifdef GUESS_TIMEOUT_EN
      check_eq("tick_time", 32'(time_left), 32'(TICKS - i));
      check_eq("tick_lose", 32'(lose), (i == TICKS) ? 32'd1 : 32'd0);
`else
      check_eq("tick_time", 32'(time_left), 32'd30);
      check_eq("tick_lose", 32'(lose), 32'd0);
`endif
      step();
    end

    // Correct guess coinciding with the expiring tick wins.
    if (playing) begin
      rst = 1'b1; step(); rst = 1'b0; step();
    end
    new_round(20);
`ifdef GUESS_TIMEOUT_EN
    for (int i = 1; i < TICKS; i++) begin
      slow_clk = 1'b1; step(); slow_clk = 1'b0; step();
    end
    check_eq("last_tick_time", 32'(time_left), 32'd1);
`endif
    guess = 7'd20; submit = 1'b1; slow_clk = 1'b1;
    step();
    submit = 1'b0; slow_clk = 1'b0;
    check_eq("race_win", 32'({win, lose}), 32'b10);
    step();

    // Reset in the middle of a round, then a fresh round on target 99.
    new_round(7);
    for (int i = 0; i < 3; i++) begin
      do_guess(100);
      step();
    end
    check_eq("mid_tries", 32'(tries), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("mid_rst");
    step();
    new_round(99);
    do_guess(99);
    check_eq("g99_win", 32'(win), 32'd1);
    check_eq("g99_tries", 32'(tries), 32'd1);
    step();

    // Randomized play against the model.
    for (int c = 0; c < 3000; c++) begin
      rand_num = WIDTH'($urandom);
      start = ($urandom_range(0, 24) == 0);
      submit = ($urandom_range(0, 2) == 0);
      slow_clk = ($urandom_range(0, 1) == 1);
      guess = ($urandom_range(0, 5) == 0) ? WIDTH'(m_target) : WIDTH'($urandom);
      rst = ($urandom_range(0, 599) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
